// File: rtl/motoro3_deadtime_guard.sv
// Dead-time guard between the 3-phase controller and the gate-driver pins.
// Optional minimum on-time is enabled by defining MOTORO3_DT_MINON_EN.
module motoro3_deadtime_guard #(
    parameter int unsigned DT_CYCLES    = 10,
    parameter int unsigned MINON_CYCLES = 5
) (
    input  logic clk,
    input  logic nRst,
    input  logic rawAHp,
    input  logic rawALp,
    input  logic rawBHp,
    input  logic rawBLp,
    input  logic rawCHp,
    input  logic rawCLp,
    input  logic m3fault,
    input  logic faultClr,
    output logic gAHp,
    output logic gALp,
    output logic gBHp,
    output logic gBLp,
    output logic gCHp,
    output logic gCLp,
    output logic faultLatched,
    output logic stErr
);

    typedef enum logic [1:0] {IDLE, HON, LON, DEAD} state_t;

    localparam logic [7:0] DT_LOAD = 8'(DT_CYCLES - 1);

    if (DT_CYCLES < 1 || DT_CYCLES > 255 || MINON_CYCLES < 1 || MINON_CYCLES > 255) begin : g_bad_param
        $error("motoro3_deadtime_guard: DT_CYCLES and MINON_CYCLES must be in 1..255");
    end

    logic [2:0] raw_h;
    logic [2:0] raw_l;
    logic [2:0] gate_h;
    logic [2:0] gate_l;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic fault_latched_q, fault_latched_d;
    logic st_err_q, st_err_d;
    logic clr_ok;
    logic fault_force;

    assign raw_h = {rawCHp, rawBHp, rawAHp};
    assign raw_l = {rawCLp, rawBLp, rawALp};

    // The first synchronizer stage feeds the latch directly, so the latch
    // sets on the same edge the second stage goes high (two edges total).
    always_comb begin
        sync1_d         = m3fault;
        sync2_d         = sync1_q;
        clr_ok          = faultClr & ~sync2_q;
        fault_force     = sync1_q | fault_latched_q;
        fault_latched_d = sync1_q | (fault_latched_q & ~clr_ok);
        st_err_d        = (|(raw_h & raw_l)) | (st_err_q & ~clr_ok);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            fault_latched_q <= 1'b0;
            st_err_q        <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            fault_latched_q <= fault_latched_d;
            st_err_q        <= st_err_d;
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_phase
        state_t     state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       req_h, req_l;
        logic       on_hold;

        assign req_h = raw_h[p] & ~raw_l[p];
        assign req_l = raw_l[p] & ~raw_h[p];

`ifdef MOTORO3_DT_MINON_EN
        localparam logic [7:0] MINON_LOAD = 8'(MINON_CYCLES - 1);
        logic [7:0] ontmr_q, ontmr_d;

        assign on_hold = (ontmr_q != '0);

        // Load on entry to an on-state, otherwise count down to zero.
        always_comb begin
            ontmr_d = ontmr_q;
            if ((state_d == HON || state_d == LON) && state_d != state_q) begin
                ontmr_d = MINON_LOAD;
            end else if (ontmr_q != '0) begin
                ontmr_d = ontmr_q - 8'd1;
            end
        end

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) ontmr_q <= '0;
            else       ontmr_q <= ontmr_d;
        end
`else
        assign on_hold = 1'b0;
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (fault_force) begin
                state_d = DEAD;
                cnt_d   = DT_LOAD;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_h)      state_d = HON;
                        else if (req_l) state_d = LON;
                    end
                    HON: begin
                        if (!req_h && !on_hold) begin
                            state_d = DEAD;
                            cnt_d   = DT_LOAD;
                        end
                    end
                    LON: begin
                        if (!req_l && !on_hold) begin
                            state_d = DEAD;
                            cnt_d   = DT_LOAD;
                        end
                    end
                    DEAD: begin
                        if (cnt_q != '0)  cnt_d   = cnt_q - 8'd1;
                        else if (req_h)   state_d = HON;
                        else if (req_l)   state_d = LON;
                        else              state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge nRst) begin
            if (!nRst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign gate_h[p] = (state_q == HON);
        assign gate_l[p] = (state_q == LON);
    end

    assign gAHp         = gate_h[0];
    assign gALp         = gate_l[0];
    assign gBHp         = gate_h[1];
    assign gBLp         = gate_l[1];
    assign gCHp         = gate_h[2];
    assign gCLp         = gate_l[2];
    assign faultLatched = fault_latched_q;
    assign stErr        = st_err_q;

endmodule
